// File: rtl/microwave_ctrl_timed.sv
// Timed microwave oven controller: countdown cook timer, PWM heater power,
// stop/hold handling and a tick-timed completion bell.
module microwave_ctrl_timed #(
  parameter int TIME_W      = 8,
  parameter int PWR_W       = 3,
  parameter int BELL_SECS   = 3,
  parameter bit AUTO_RESUME = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              door,
  input  logic              start,
  input  logic              stop,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PWR_W-1:0]  power_in,
  output logic              heat,
  output logic              light,
  output logic              bell,
  output logic [TIME_W-1:0] remaining,
  output logic              busy
);

  localparam int BELL_W = $clog2(BELL_SECS + 1);

  localparam logic [TIME_W-1:0] TIME_ZERO = {TIME_W{1'b0}};
  localparam logic [TIME_W-1:0] TIME_ONE  = {{(TIME_W-1){1'b0}}, 1'b1};
  localparam logic [PWR_W-1:0]  PWM_ZERO  = {PWR_W{1'b0}};
  localparam logic [PWR_W-1:0]  PWM_ONE   = {{(PWR_W-1){1'b0}}, 1'b1};
  localparam logic [BELL_W-1:0] BELL_ZERO = {BELL_W{1'b0}};
  localparam logic [BELL_W-1:0] BELL_ONE  = {{(BELL_W-1){1'b0}}, 1'b1};
  localparam logic [BELL_W-1:0] BELL_LOAD = BELL_W'(BELL_SECS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OPEN  = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_HOLD  = 3'd4,
    S_BELL  = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [TIME_W-1:0]  remaining_r, remaining_s;
  logic [PWR_W-1:0]   power_r, power_s;
  logic [PWR_W-1:0]   pwm_r, pwm_s;
  logic [BELL_W-1:0]  bell_cnt_r, bell_cnt_s;
  logic               cancel_r, cancel_s;
  logic               heat_r, light_r, bell_r, busy_r;
  logic               heat_s, light_s, bell_s, busy_s;

  // Next-state, timer, power, PWM and bell-counter logic
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    power_s     = power_r;
    pwm_s       = (state_r == S_COOK) ? (pwm_r + PWM_ONE) : pwm_r;
    bell_cnt_s  = bell_cnt_r;
    cancel_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (door) begin
          state_s = S_OPEN;
        end else if (stop) begin
          remaining_s = TIME_ZERO;
        end else if (start && (time_in != TIME_ZERO)) begin
          state_s     = S_COOK;
          remaining_s = time_in;
          power_s     = power_in;
          pwm_s       = PWM_ZERO;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_OPEN: begin
        if (!door) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_OPEN;
        end
      end
      S_COOK: begin
        if (door) begin
          state_s = S_PAUSE;
        end else if (stop) begin
          state_s = S_HOLD;
        end else if (tick) begin
          if (remaining_r == TIME_ONE) begin
            state_s     = S_BELL;
            remaining_s = TIME_ZERO;
            bell_cnt_s  = BELL_LOAD;
          end else if (remaining_r != TIME_ZERO) begin
            remaining_s = remaining_r - TIME_ONE;
          end else begin
            remaining_s = TIME_ZERO;
          end
        end else begin
          state_s = S_COOK;
        end
      end
      S_PAUSE: begin
        // A stop while paused is remembered until the door closes
        if (!door) begin
          if (stop || cancel_r) begin
            state_s     = S_IDLE;
            remaining_s = TIME_ZERO;
          end else if (AUTO_RESUME) begin
            state_s = S_COOK;
          end else begin
            state_s = S_HOLD;
          end
        end else if (stop) begin
          remaining_s = TIME_ZERO;
          cancel_s    = 1'b1;
        end else begin
          cancel_s = cancel_r;
        end
      end
      S_HOLD: begin
        if (door) begin
          state_s = S_PAUSE;
        end else if (stop) begin
          state_s     = S_IDLE;
          remaining_s = TIME_ZERO;
        end else if (start) begin
          state_s = S_COOK;
          power_s = power_in;
        end else begin
          state_s = S_HOLD;
        end
      end
      S_BELL: begin
        if (door) begin
          state_s    = S_OPEN;
          bell_cnt_s = BELL_ZERO;
        end else if (stop) begin
          state_s    = S_IDLE;
          bell_cnt_s = BELL_ZERO;
        end else if (tick) begin
          if (bell_cnt_r <= BELL_ONE) begin
            state_s    = S_IDLE;
            bell_cnt_s = BELL_ZERO;
          end else begin
            bell_cnt_s = bell_cnt_r - BELL_ONE;
          end
        end else begin
          state_s = S_BELL;
        end
      end
      default: begin
        state_s     = S_IDLE;
        remaining_s = TIME_ZERO;
        bell_cnt_s  = BELL_ZERO;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track state_r
  always_comb begin
    heat_s  = (state_s == S_COOK) && (pwm_s < power_s);
    light_s = (state_s == S_OPEN) || (state_s == S_COOK) || (state_s == S_PAUSE);
    bell_s  = (state_s == S_BELL);
    busy_s  = (state_s == S_COOK) || (state_s == S_PAUSE) || (state_s == S_HOLD);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      remaining_r <= TIME_ZERO;
      power_r     <= PWM_ZERO;
      pwm_r       <= PWM_ZERO;
      bell_cnt_r  <= BELL_ZERO;
      cancel_r    <= 1'b0;
      heat_r      <= 1'b0;
      light_r     <= 1'b0;
      bell_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      power_r     <= power_s;
      pwm_r       <= pwm_s;
      bell_cnt_r  <= bell_cnt_s;
      cancel_r    <= cancel_s;
      heat_r      <= heat_s;
      light_r     <= light_s;
      bell_r      <= bell_s;
      busy_r      <= busy_s;
    end
  end

  assign heat      = heat_r;
  assign light     = light_r;
  assign bell      = bell_r;
  assign busy      = busy_r;
  assign remaining = remaining_r;

endmodule

// File: tb/tb_microwave_ctrl_timed.sv
// Directed table-driven bench for microwave_ctrl_timed (default parameters).
module tb_microwave_ctrl_timed;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       door;
  logic       start;
  logic       stop;
  logic [7:0] time_in;
  logic [2:0] power_in;
  logic       heat;
  logic       light;
  logic       bell;
  logic [7:0] remaining;
  logic       busy;

  int checks;
  int failures;

  microwave_ctrl_timed dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .door     (door),
    .start    (start),
    .stop     (stop),
    .time_in  (time_in),
    .power_in (power_in),
    .heat     (heat),
    .light    (light),
    .bell     (bell),
    .remaining(remaining),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ins = {door,start,stop,tick}; outs = {heat,light,bell,busy}
  typedef struct {
    string      name;
    logic [3:0] ins;
    logic [7:0] tin;
    logic [2:0] pin;
    logic [3:0] outs;
    logic [7:0] rem;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [3:0] i, logic [7:0] ti, logic [2:0] pi,
                              logic [3:0] o, logic [7:0] r);
    vec_t x;
    x.name = n; x.ins = i; x.tin = ti; x.pin = pi; x.outs = o; x.rem = r;
    return x;
  endfunction

  task automatic check(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic drive(logic [3:0] i, logic [7:0] ti, logic [2:0] pi);
    {door, start, stop, tick} = i;
    time_in  = ti;
    power_in = pi;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] outv();
    return {heat, light, bell, busy, remaining};
  endfunction

  int heat_cnt;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; door = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    time_in = 8'd0; power_in = 3'd0;

    // normal cook, power 7, 3 s, then 3-tick bell
    vecs.push_back(mk("a_start",   4'b0100, 8'd3,  3'd7, 4'b1101, 8'd3));
    vecs.push_back(mk("a_pwm1",    4'b0000, 8'd3,  3'd7, 4'b1101, 8'd3));
    vecs.push_back(mk("a_tick1",   4'b0001, 8'd0,  3'd0, 4'b1101, 8'd2));
    vecs.push_back(mk("a_pwm3",    4'b0000, 8'd0,  3'd0, 4'b1101, 8'd2));
    vecs.push_back(mk("a_pwm4",    4'b0000, 8'd0,  3'd0, 4'b1101, 8'd2));
    vecs.push_back(mk("a_pwm5",    4'b0000, 8'd0,  3'd0, 4'b1101, 8'd2));
    vecs.push_back(mk("a_pwm6",    4'b0000, 8'd0,  3'd0, 4'b1101, 8'd2));
    vecs.push_back(mk("a_pwm7off", 4'b0000, 8'd0,  3'd0, 4'b0101, 8'd2));
    vecs.push_back(mk("a_tick2",   4'b0001, 8'd0,  3'd0, 4'b1101, 8'd1));
    vecs.push_back(mk("a_bell",    4'b0001, 8'd0,  3'd0, 4'b0010, 8'd0));
    vecs.push_back(mk("a_bellgap", 4'b0000, 8'd0,  3'd0, 4'b0010, 8'd0));
    vecs.push_back(mk("a_bellt1",  4'b0001, 8'd0,  3'd0, 4'b0010, 8'd0));
    vecs.push_back(mk("a_bellt2",  4'b0001, 8'd0,  3'd0, 4'b0010, 8'd0));
    vecs.push_back(mk("a_bellst",  4'b0100, 8'd5,  3'd1, 4'b0010, 8'd0));
    vecs.push_back(mk("a_bellend", 4'b0001, 8'd0,  3'd0, 4'b0000, 8'd0));
    vecs.push_back(mk("a_idletk",  4'b0001, 8'd0,  3'd0, 4'b0000, 8'd0));
    // door interrupt, hold, resume from 6 at new power 2
    vecs.push_back(mk("b_start",   4'b0100, 8'd10, 3'd4, 4'b1101, 8'd10));
    vecs.push_back(mk("b_tick1",   4'b0001, 8'd0,  3'd0, 4'b1101, 8'd9));
    vecs.push_back(mk("b_tick2",   4'b0001, 8'd0,  3'd0, 4'b1101, 8'd8));
    vecs.push_back(mk("b_tick3",   4'b0001, 8'd0,  3'd0, 4'b1101, 8'd7));
    vecs.push_back(mk("b_tick4",   4'b0001, 8'd0,  3'd0, 4'b0101, 8'd6));
    vecs.push_back(mk("b_pause",   4'b1000, 8'd0,  3'd0, 4'b0101, 8'd6));
    vecs.push_back(mk("b_pausetk", 4'b1001, 8'd0,  3'd0, 4'b0101, 8'd6));
    vecs.push_back(mk("b_hold",    4'b0000, 8'd0,  3'd0, 4'b0001, 8'd6));
    vecs.push_back(mk("b_holdtk",  4'b0001, 8'd0,  3'd0, 4'b0001, 8'd6));
    vecs.push_back(mk("b_resume",  4'b0100, 8'd99, 3'd2, 4'b0101, 8'd6));
    vecs.push_back(mk("b_pwm6",    4'b0001, 8'd0,  3'd0, 4'b0101, 8'd5));
    vecs.push_back(mk("b_pwm7",    4'b0000, 8'd0,  3'd0, 4'b0101, 8'd5));
    vecs.push_back(mk("b_pwm0",    4'b0000, 8'd0,  3'd0, 4'b1101, 8'd5));
    vecs.push_back(mk("b_pwm1",    4'b0000, 8'd0,  3'd0, 4'b1101, 8'd5));
    vecs.push_back(mk("b_stop1",   4'b0010, 8'd0,  3'd0, 4'b0001, 8'd5));
    vecs.push_back(mk("b_stop2",   4'b0010, 8'd0,  3'd0, 4'b0000, 8'd0));
    // stop sequence
    vecs.push_back(mk("c_start",   4'b0100, 8'd8,  3'd1, 4'b1101, 8'd8));
    vecs.push_back(mk("c_stop1",   4'b0010, 8'd0,  3'd0, 4'b0001, 8'd8));
    vecs.push_back(mk("c_stop2",   4'b0010, 8'd0,  3'd0, 4'b0000, 8'd0));
    // zero time and door-open handling
    vecs.push_back(mk("d_zero",    4'b0100, 8'd0,  3'd5, 4'b0000, 8'd0));
    vecs.push_back(mk("d_open",    4'b1000, 8'd0,  3'd0, 4'b0100, 8'd0));
    vecs.push_back(mk("d_openst",  4'b1100, 8'd4,  3'd3, 4'b0100, 8'd0));
    vecs.push_back(mk("d_opensp",  4'b1010, 8'd0,  3'd0, 4'b0100, 8'd0));
    vecs.push_back(mk("d_close",   4'b0000, 8'd0,  3'd0, 4'b0000, 8'd0));
    // power 0 cook still reaches bell; door in bell cuts it
    vecs.push_back(mk("e_start",   4'b0100, 8'd2,  3'd0, 4'b0101, 8'd2));
    vecs.push_back(mk("e_tick1",   4'b0001, 8'd0,  3'd0, 4'b0101, 8'd1));
    vecs.push_back(mk("e_gap",     4'b0000, 8'd0,  3'd0, 4'b0101, 8'd1));
    vecs.push_back(mk("e_bell",    4'b0001, 8'd0,  3'd0, 4'b0010, 8'd0));
    vecs.push_back(mk("e_belldoor",4'b1000, 8'd0,  3'd0, 4'b0100, 8'd0));
    vecs.push_back(mk("e_close",   4'b0000, 8'd0,  3'd0, 4'b0000, 8'd0));
    // door+tick at remaining 1, then cancel while paused
    vecs.push_back(mk("f_start",   4'b0100, 8'd1,  3'd3, 4'b1101, 8'd1));
    vecs.push_back(mk("f_doortk",  4'b1001, 8'd0,  3'd0, 4'b0101, 8'd1));
    vecs.push_back(mk("f_pstop",   4'b1010, 8'd0,  3'd0, 4'b0101, 8'd0));
    vecs.push_back(mk("f_pwait",   4'b1000, 8'd0,  3'd0, 4'b0101, 8'd0));
    vecs.push_back(mk("f_close",   4'b0000, 8'd0,  3'd0, 4'b0000, 8'd0));
    // stop during bell
    vecs.push_back(mk("g_start",   4'b0100, 8'd1,  3'd0, 4'b0101, 8'd1));
    vecs.push_back(mk("g_bell",    4'b0001, 8'd0,  3'd0, 4'b0010, 8'd0));
    vecs.push_back(mk("g_stop",    4'b0010, 8'd0,  3'd0, 4'b0000, 8'd0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(outv()), 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ins, vecs[i].tin, vecs[i].pin);
      check(vecs[i].name, 32'(outv()), 32'({vecs[i].outs, vecs[i].rem}));
    end

    // duty at power 7: 14 of 16 cycles with heat
    drive(4'b0100, 8'd200, 3'd7);
    heat_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (heat) heat_cnt++;
      drive(4'b0000, 8'd0, 3'd0);
    end
    check("duty_p7", 32'(heat_cnt), 32'd14);
    drive(4'b0010, 8'd0, 3'd0);
    drive(4'b0010, 8'd0, 3'd0);
    check("duty_exit", 32'(outv()), 32'h0);

    // reset mid-cook, with rst taking priority over door/start
    drive(4'b0100, 8'd5, 3'd3);
    drive(4'b0001, 8'd0, 3'd0);
    drive(4'b0001, 8'd0, 3'd0);
    check("rst_precook", 32'(remaining), 32'd3);
    rst = 1'b1;
    drive(4'b1100, 8'd9, 3'd7);
    check("rst_midcook", 32'(outv()), 32'h0);
    rst = 1'b0;
    drive(4'b0000, 8'd0, 3'd0);
    check("rst_after", 32'(outv()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
